// File: rtl/dino_pkg.sv
// Shared dinosaur state and sprite codes, also used by the renderer and score logic.
package dino_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DUCK = 3'd2,
    ST_JUMP = 3'd3,
    ST_DEAD = 3'd4
  } dino_state_e;

  localparam int unsigned SPR_IDLE = 6;
  localparam int unsigned SPR_DEAD = 2;
  localparam int unsigned SPR_JUMP = 3;

  function automatic logic is_anim(dino_state_e s);
    return (s == ST_RUN) || (s == ST_DUCK);
  endfunction

endpackage

// File: rtl/dino_sprite_fsm_if.sv
// Bundle between physics/input logic (master) and the sprite-select FSM (slave).
interface dino_sprite_fsm_if #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned RUN_FRAMES = 2
);
  localparam int unsigned FW = $clog2(RUN_FRAMES) + 1;

  logic             tick;
  logic             game_start;
  logic             restart;
  logic             airborne;
  logic             on_ground;
  logic             duck;
  logic             dead;
  logic [SEL_W-1:0] sprite_sel;
  logic [2:0]       state;
  logic [FW-1:0]    frame_idx;
  logic             frame_adv;

  modport master (
    output tick, game_start, restart, airborne, on_ground, duck, dead,
    input  sprite_sel, state, frame_idx, frame_adv
  );

  modport slave (
    input  tick, game_start, restart, airborne, on_ground, duck, dead,
    output sprite_sel, state, frame_idx, frame_adv
  );

endinterface

// File: rtl/dino_anim_counter.sv
// Tick-driven run/duck animation counter: divides ticks by FRAME_DIV, wraps at RUN_FRAMES.
module dino_anim_counter #(
  parameter int unsigned RUN_FRAMES = 2,
  parameter int unsigned FRAME_DIV  = 6,
  localparam int unsigned FW        = $clog2(RUN_FRAMES) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          enable,
  input  logic          clear,
  output logic [FW-1:0] frame_idx,
  output logic [FW-1:0] frame_nxt,
  output logic          frame_adv
);
  localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic [FW-1:0]   frame_q;
  logic            adv_q, adv_d;

  always_comb begin
    div_d     = div_q;
    frame_nxt = frame_q;
    adv_d     = 1'b0;
    if (clear) begin
      div_d     = '0;
      frame_nxt = '0;
    end else if (enable && tick) begin
      if (div_q == DivW'(FRAME_DIV - 1)) begin
        div_d     = '0;
        adv_d     = 1'b1;
        frame_nxt = (frame_q == FW'(RUN_FRAMES - 1)) ? '0 : frame_q + FW'(1);
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      frame_q <= '0;
      adv_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_nxt;
      adv_q   <= adv_d;
    end
  end

  assign frame_idx = frame_q;
  assign frame_adv = adv_q;

endmodule

// File: rtl/dino_sprite_fsm.sv
// Registered dinosaur sprite-select FSM: IDLE/RUN/DUCK/JUMP/DEAD with animated run/duck legs.
module dino_sprite_fsm
  import dino_pkg::*;
#(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned RUN_FRAMES = 2,
  parameter int unsigned FRAME_DIV  = 6,
  parameter int unsigned RUN_BASE   = 8,
  parameter int unsigned DUCK_BASE  = 12
) (
  input logic              clk,
  input logic              rst_n,
  dino_sprite_fsm_if.slave bus
);
  localparam int unsigned FW = $clog2(RUN_FRAMES) + 1;

  dino_state_e      state_q, state_d;
  logic [SEL_W-1:0] sprite_q, sprite_d;
  logic [FW-1:0]    frame_nxt;
  logic             anim_en;
  logic             anim_clr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.dead)            state_d = ST_DEAD;
        else if (bus.game_start) state_d = ST_RUN;
      end
      ST_DEAD: begin
        if (bus.restart && !bus.dead) state_d = ST_IDLE;
      end
      default: begin
        // Neither airborne nor on_ground is the landing/take-off gap: hold.
        if (bus.dead)                       state_d = ST_DEAD;
        else if (bus.airborne)              state_d = ST_JUMP;
        else if (bus.on_ground && bus.duck) state_d = ST_DUCK;
        else if (bus.on_ground)             state_d = ST_RUN;
      end
    endcase
  end

  // Only count while the legs are actually moving on the ground; RUN<->DUCK keeps phase.
  assign anim_en  = is_anim(state_q) && bus.on_ground && !bus.airborne && !bus.dead;
  assign anim_clr = (is_anim(state_d) && !is_anim(state_q)) ||
                    ((state_q == ST_DEAD) && (state_d == ST_IDLE));

  dino_anim_counter #(
    .RUN_FRAMES(RUN_FRAMES),
    .FRAME_DIV (FRAME_DIV)
  ) u_anim (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (bus.tick),
    .enable   (anim_en),
    .clear    (anim_clr),
    .frame_idx(bus.frame_idx),
    .frame_nxt(frame_nxt),
    .frame_adv(bus.frame_adv)
  );

  always_comb begin
    sprite_d = SEL_W'(SPR_IDLE);
    case (state_d)
      ST_RUN:  sprite_d = SEL_W'(RUN_BASE + 32'(frame_nxt));
      ST_DUCK: sprite_d = SEL_W'(DUCK_BASE + 32'(frame_nxt));
      ST_JUMP: sprite_d = SEL_W'(SPR_JUMP);
      ST_DEAD: sprite_d = SEL_W'(SPR_DEAD);
      default: sprite_d = SEL_W'(SPR_IDLE);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sprite_q <= SEL_W'(SPR_IDLE);
    end else begin
      state_q  <= state_d;
      sprite_q <= sprite_d;
    end
  end

  assign bus.sprite_sel = sprite_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_dino_sprite_fsm.sv
// Scoreboard bench for dino_sprite_fsm: driver pushes model predictions, monitor pops and compares.
module tb_dino_sprite_fsm;

  localparam int SelW = 4;
  localparam int RunFrames = 2;
  localparam int FrameDiv = 6;
  localparam int RunBase = 8;
  localparam int DuckBase = 12;

  localparam int MIdle = 0, MRun = 1, MDuck = 2, MJump = 3, MDead = 4;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] spr;
    logic [1:0] fi;
    logic       adv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dino_sprite_fsm_if #(.SEL_W(SelW), .RUN_FRAMES(RunFrames)) bus ();

  dino_sprite_fsm #(
    .SEL_W     (SelW),
    .RUN_FRAMES(RunFrames),
    .FRAME_DIV (FrameDiv),
    .RUN_BASE  (RunBase),
    .DUCK_BASE (DuckBase)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  // Reference model: game state, leg frame and tick count since the last frame change.
  int m_st = MIdle;
  int m_frame = 0;
  int m_div = 0;

  function automatic int spr_of(int st, int fr);
    case (st)
      MRun:    return (RunBase + fr) % 16;
      MDuck:   return (DuckBase + fr) % 16;
      MJump:   return 3;
      MDead:   return 2;
      default: return 6;
    endcase
  endfunction

  function automatic bit legs(int st);
    return st == MRun || st == MDuck;
  endfunction

  task automatic cyc(input bit tk, gs, rs, air, gnd, dk, dd);
    int   nxt;
    bit   adv;
    exp_t e;
    @(negedge clk);
    bus.tick = tk; bus.game_start = gs; bus.restart = rs;
    bus.airborne = air; bus.on_ground = gnd; bus.duck = dk; bus.dead = dd;
    adv = 1'b0;
    nxt = m_st;
    if (m_st == MIdle) begin
      if (dd) nxt = MDead;
      else if (gs) nxt = MRun;
    end else if (m_st == MDead) begin
      if (rs && !dd) nxt = MIdle;
    end else begin
      if (dd) nxt = MDead;
      else if (air) nxt = MJump;
      else if (gnd) nxt = dk ? MDuck : MRun;
    end
    if ((legs(nxt) && !legs(m_st)) || (m_st == MDead && nxt == MIdle)) begin
      m_frame = 0;
      m_div = 0;
    end else if (legs(m_st) && gnd && !air && !dd && tk) begin
      m_div++;
      if (m_div == FrameDiv) begin
        m_div = 0;
        m_frame = (m_frame + 1) % RunFrames;
        adv = 1'b1;
      end
    end
    m_st = nxt;
    e.st = 3'(m_st);
    e.spr = 4'(spr_of(m_st, m_frame));
    e.fi = 2'(m_frame);
    e.adv = adv;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.tick = 0; bus.game_start = 0; bus.restart = 0;
    bus.airborne = 0; bus.on_ground = 0; bus.duck = 0; bus.dead = 0;
    rst_n = 1'b0;
    m_st = MIdle; m_frame = 0; m_div = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string name);
    n_cmp++;
    if (bus.state !== 3'd0 || bus.sprite_sel !== 4'd6 || bus.frame_idx !== 2'd0 ||
        bus.frame_adv !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got st=%0d spr=%0d fi=%0d adv=%0b, need st=0 spr=6 fi=0 adv=0",
               name, bus.state, bus.sprite_sel, bus.frame_idx, bus.frame_adv);
    end
  endtask

  // Monitor: outputs are valid every cycle out of reset.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.state !== e.st || bus.sprite_sel !== e.spr || bus.frame_idx !== e.fi ||
          bus.frame_adv !== e.adv) begin
        n_bad++;
        $display("FAIL out_check t=%0t: got st=%0d spr=%0d fi=%0d adv=%0b, need st=%0d spr=%0d fi=%0d adv=%0b",
                 $time, bus.state, bus.sprite_sel, bus.frame_idx, bus.frame_adv,
                 e.st, e.spr, e.fi, e.adv);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 0; bus.game_start = 0; bus.restart = 0;
    bus.airborne = 0; bus.on_ground = 0; bus.duck = 0; bus.dead = 0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset_state");
    @(negedge clk) rst_n = 1'b1;

    // Start and run through a full two-frame animation cycle.
    cyc(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(i[0], 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 40 && m_frame != 1; i++) cyc(1, 0, 0, 0, 1, 0, 0);
    // Duck and release at frame 1, ticking through.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 0, 0);
    // Jump with ticks, then land.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // Duck frame 0 then a three-cycle gap with ticks.
    cyc(0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    // Death while airborne, sticky against restart+dead, then restart.
    cyc(0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0,
          ($urandom % 4) == 0, ($urandom % 5) != 0, ($urandom % 3) == 0,
          ($urandom % 40) == 0);
    end

    // Async reset mid-RUN at frame 1.
    do_reset();
    cyc(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 40 && m_frame != 1; i++) cyc(1, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #3;
    n_cmp++;
    if (bus.frame_idx !== 2'd1 || bus.state !== 3'd1) begin
      n_bad++;
      $display("FAIL pre_reset_run: got st=%0d fi=%0d, need st=1 fi=1", bus.state, bus.frame_idx);
    end
    rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    do_reset();
    cyc(0, 0, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
